// File: rtl/riscv_fetch_buffer.sv
// riscv_fetch_buffer
//
// Instruction fetch stage in front of the single-cycle RISC-V datapath.
// Owns the PC, issues sequential word fetches to a variable-latency
// instruction memory, and buffers returned words together with their PCs
// in a small in-order FIFO that the datapath drains.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where valid && ready are both high. valid never depends on ready of
// the same channel. The response channel has no ready: every accepted
// request produces exactly one imem_rsp_valid pulse, in request order.
//
// Ports
//   clk, a_rst        clock, asynchronous active-high reset
//   imem_req_valid    fetch request valid (credit limited)
//   imem_req_addr     fetch word address (always the current fetch PC)
//   imem_req_ready    memory accepts the request
//   imem_rsp_valid    returned instruction valid
//   imem_rsp_instr    returned instruction word
//   redirect_valid    flush buffer and restart fetch at redirect_pc
//   redirect_pc       new fetch address, low two bits ignored
//   instr_valid       FIFO head valid for the datapath
//   instr, instr_pc   FIFO head word and its PC (0 when not valid)
//   instr_ready       datapath consumes the head
module riscv_fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        a_rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  // Wide enough to add three CW-bit counters without overflow.
  localparam int SW = CW + 2;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];

  logic [SW-1:0] w_used;
  logic          w_credit;
  logic          w_req_fire;
  logic          w_rsp_counted;
  logic          w_rsp_drop;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_target;

  // Every buffered entry, live request and to-be-dropped request holds a
  // credit, so a kept response always finds a free FIFO slot.
  assign w_used   = SW'(r_count) + SW'(r_outstanding) + SW'(r_discard);
  assign w_credit = (w_used < SW'(DEPTH));

  assign imem_req_valid = !a_rst && !redirect_valid && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // A response with nothing in flight is a protocol error and is ignored.
  assign w_rsp_counted = imem_rsp_valid && ((r_discard != '0) || (r_outstanding != '0));
  assign w_rsp_drop    = imem_rsp_valid && (r_discard != '0);
  assign w_push        = imem_rsp_valid && (r_discard == '0) && (r_outstanding != '0)
                         && !redirect_valid;

  assign instr_valid = (r_count != '0) && !redirect_valid;
  assign w_pop       = instr_valid && instr_ready;
  assign instr       = instr_valid ? r_instr_mem[r_rd_ptr] : 32'h0;
  assign instr_pc    = instr_valid ? r_pc_mem[r_rd_ptr]    : 32'h0;

  assign w_redirect_target = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc    <= w_redirect_target;
      r_rsp_pc      <= w_redirect_target;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      // All live requests become stale; a response landing this cycle
      // retires one of them (it is dropped either way).
      r_discard     <= r_discard + r_outstanding - (w_rsp_counted ? CW'(1) : CW'(0));
      r_outstanding <= '0;
    end else begin
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rsp_pc <= r_rsp_pc + 32'd4;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_push);
      if (w_rsp_drop) begin
        r_discard <= r_discard - CW'(1);
      end
    end
  end

  // Storage needs no reset: reads are masked by instr_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr_ptr]    <= r_rsp_pc;
      r_instr_mem[r_wr_ptr] <= imem_rsp_instr;
    end
  end

endmodule
